mm_iddmm_modexp_seq: RTL and testbench
======================================

// Module: mm_iddmm_modexp_seq
// PURPOSE
//  Montgomery modular-exponentiation sequencer in front of mm_iddmm_sp (K-bit word, N-word IDDMM core).
//  Holds base, accumulator, modulus and exponent in internal word RAMs.
//  Scans exponent MSB-first; per bit issues one square (acc*acc) and, if the bit is 1, one multiply (acc*base).
//  Streams operands into the core, collects res words into acc. Result: acc = base^e (Montgomery domain).
// PARAMETERS
//  K   128  word width (bits)
//  N   32   words per operand; operand width K*N
//  EW  $clog2(K*N+1)  width of exp_bits
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  cfg_wr_ena   in   1        host word write (ignored while busy)
//  cfg_wr_sel   in   2        0=base 1=acc(init, Montgomery one) 2=modulus 3=exponent
//  cfg_wr_addr  in   log2N    word index, 0 = LS word
//  cfg_wr_data  in   K        word data
//  cfg_m1       in   K        -m^-1 mod 2^K; sampled on accepted start
//  exp_bits     in   EW       exponent bits to process (0..K*N); sampled on accepted start
//  start        in   1        1-cycle pulse; accepted only when !busy
//  abort        in   1        sync abort; busy->IDLE next cycle
//  busy         out  1        high from cycle after accepted start until done/abort
//  done         out  1        1-cycle pulse, result valid in acc
//  err          out  1        sticky: core returned !=N res words in a task; cleared on accepted start
//  rd_addr      in   log2N    acc readback address
//  rd_data      out  K        acc[rd_addr], 1-cycle latency; undefined while busy
//  mm_wr_ena    out  1        core RAM write enable
//  mm_wr_addr   out  log2N    core RAM address
//  mm_wr_x/y/m  out  K each   core operand words
//  mm_wr_m1     out  K        registered cfg_m1
//  mm_task_req  out  1        core task request (level)
//  mm_task_end  in   1        core task complete
//  mm_res_val   in   1        core result word valid
//  mm_res       in   K        core result word, LS word first
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, bit index 0, err 0. RAM contents not reset.
//  FSM: IDLE -> (start && exp_bits==0) DONE; (start) LOAD, bit=exp_bits-1, op=SQR.
//   LOAD: N cycles, mm_wr_ena=1, addr 0..N-1; x=acc[a]; y=acc[a] (SQR) or base[a] (MUL); m=mod[a] -> REQ.
//   REQ: mm_task_req=1 from first cycle until cycle after mm_task_end seen (then 0); each mm_res_val
//    writes mm_res to acc[wcnt], wcnt++ -> NEXT on task_end.
//   NEXT: wcnt!=N sets err. if op==SQR && exp[bit]: op=MUL -> LOAD. else if bit==0 -> DONE;
//    else bit--, op=SQR -> LOAD.
//   DONE: done=1 one cycle -> IDLE.
//  RAM read latency 1: LOAD address pipeline one cycle ahead of mm_wr_* outputs; mm_wr_ena aligned to data.
//  acc overwrite safe: core has copied operands before first res_val; no acc read during REQ.
//  Exponent bits above exp_bits-1 ignored. exp_bits>K*N clamps to K*N.
//  Task count = exp_bits + popcount(e[exp_bits-1:0]).
//  Simultaneous start+cfg_wr_ena in IDLE: write lands, start uses new value (write port ahead of load).
//  abort: mm_task_req dropped immediately; res_val words after abort discarded; acc partially written; no done.
//  start while busy ignored; rst_n low mid-op: immediate IDLE, outputs 0.
// STRUCTURE
//  Package mm_iddmm_pkg: state enum (IDLE/LOAD/REQ/NEXT/DONE), op enum (SQR/MUL), cfg_wr_sel codes.
//  Sub-module: simple_ram (1W/1R, sync read), 4 instances: base, acc (2R via rd_addr mux when idle), mod, exp.
//  Exp bit select: exp word = bit>>log2K, bit = bit[log2K-1:0]; word fetched one cycle before NEXT.
// TESTING (bench: mm_iddmm_sp or behavioural Montgomery model; K=16,N=2 unless stated)
//  1 m=0xFFFFFFFB, m1=-m^-1 mod 2^16, acc=5, base=10, exp_bits=0 -> done 2 cycles after start, acc=5, 0 tasks.
//  2 same, e=5, exp_bits=3 -> 5 tasks (S,M,S,S,M), acc=0xA0 (2^5*R mod m).
//  3 K=128,N=32, 4096-bit m/x from bench vectors, e=65537, exp_bits=17 -> 19 tasks, acc = software model.
//  4 start while busy, cfg writes while busy -> no effect on task count or result.
//  5 abort during REQ of 2nd task -> busy low next cycle, no done, mm_task_req 0; restart gives case-2 result.
//  6 model returns N-1 res words -> err=1 at end; rst_n pulse mid-LOAD -> all outputs 0, IDLE.

Source files
------------

// File: rtl/mm_iddmm_pkg.sv
// Shared types for the IDDMM modular-exponentiation sequencer.
package mm_iddmm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef enum logic {
    OP_SQR,
    OP_MUL
  } op_t;

  // cfg_wr_sel codes
  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_ACC  = 2'd1;
  localparam logic [1:0] SEL_MOD  = 2'd2;
  localparam logic [1:0] SEL_EXP  = 2'd3;

endpackage

// File: rtl/simple_ram.sv
// Single write port, single synchronous read port word RAM.
// Only the read register is reset; array contents are not.
module simple_ram #(
  parameter int unsigned W  = 16,
  parameter int unsigned D  = 2,
  parameter int unsigned AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [D];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read, one cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/mm_iddmm_modexp_seq.sv
// Montgomery modular-exponentiation sequencer feeding an IDDMM core.
// Scans the exponent MSB first: one square per bit, plus one multiply
// when the bit is set. Results stream back into the accumulator RAM.
module mm_iddmm_modexp_seq
  import mm_iddmm_pkg::*;
#(
  parameter  int unsigned K  = 128,
  parameter  int unsigned N  = 32,
  parameter  int unsigned EW = $clog2(K*N+1),
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_wr_ena,
  input  logic [1:0]    cfg_wr_sel,
  input  logic [AW-1:0] cfg_wr_addr,
  input  logic [K-1:0]  cfg_wr_data,
  input  logic [K-1:0]  cfg_m1,
  input  logic [EW-1:0] exp_bits,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [AW-1:0] rd_addr,
  output logic [K-1:0]  rd_data,
  output logic          mm_wr_ena,
  output logic [AW-1:0] mm_wr_addr,
  output logic [K-1:0]  mm_wr_x,
  output logic [K-1:0]  mm_wr_y,
  output logic [K-1:0]  mm_wr_m,
  output logic [K-1:0]  mm_wr_m1,
  output logic          mm_task_req,
  input  logic          mm_task_end,
  input  logic          mm_res_val,
  input  logic [K-1:0]  mm_res
);

  localparam int unsigned LK = $clog2(K);
  localparam int unsigned BW = $clog2(K*N);
  localparam int unsigned CW = $clog2(N+2);
  localparam logic [EW-1:0] KN_BITS = EW'(K*N);
  localparam logic [CW-1:0] N_WORDS = CW'(N);
  localparam logic [AW-1:0] LAST_A  = AW'(N-1);

  state_t          state;
  op_t             op;
  logic [BW-1:0]   bit_idx;
  logic [AW-1:0]   ld_addr;
  logic [CW-1:0]   wcnt;
  logic [EW-1:0]   eb;
  logic            host_we;
  logic            acc_we;
  logic [AW-1:0]   acc_waddr;
  logic [K-1:0]    acc_wdata;
  logic [AW-1:0]   acc_raddr;
  logic [K-1:0]    acc_q, base_q, mod_q, exp_q;
  logic            exp_bit;

  assign eb        = (exp_bits > KN_BITS) ? KN_BITS : exp_bits;
  assign host_we   = (state == ST_IDLE) && cfg_wr_ena;
  assign acc_raddr = (state == ST_LOAD) ? ld_addr : rd_addr;
  assign exp_bit   = exp_q[bit_idx[LK-1:0]];

  assign mm_wr_x = acc_q;
  assign mm_wr_y = (op == OP_MUL) ? base_q : acc_q;
  assign mm_wr_m = mod_q;
  assign rd_data = acc_q;

  // acc write port: host in IDLE, core results while a task is in flight
  always_comb begin
    acc_we    = host_we && (cfg_wr_sel == SEL_ACC);
    acc_waddr = cfg_wr_addr;
    acc_wdata = cfg_wr_data;
    if (state == ST_REQ) begin
      acc_we    = mm_res_val && (wcnt < N_WORDS);
      acc_waddr = wcnt[AW-1:0];
      acc_wdata = mm_res;
    end
  end

  simple_ram #(.W(K), .D(N), .AW(AW)) u_base (
    .clk(clk), .rst_n(rst_n), .we(host_we && (cfg_wr_sel == SEL_BASE)),
    .waddr(cfg_wr_addr), .wdata(cfg_wr_data), .raddr(ld_addr), .rdata(base_q));

  simple_ram #(.W(K), .D(N), .AW(AW)) u_acc (
    .clk(clk), .rst_n(rst_n), .we(acc_we),
    .waddr(acc_waddr), .wdata(acc_wdata), .raddr(acc_raddr), .rdata(acc_q));

  simple_ram #(.W(K), .D(N), .AW(AW)) u_mod (
    .clk(clk), .rst_n(rst_n), .we(host_we && (cfg_wr_sel == SEL_MOD)),
    .waddr(cfg_wr_addr), .wdata(cfg_wr_data), .raddr(ld_addr), .rdata(mod_q));

  // exponent word for the current bit is read continuously; it is settled
  // long before NEXT since bit_idx only changes on leaving NEXT
  simple_ram #(.W(K), .D(N), .AW(AW)) u_exp (
    .clk(clk), .rst_n(rst_n), .we(host_we && (cfg_wr_sel == SEL_EXP)),
    .waddr(cfg_wr_addr), .wdata(cfg_wr_data), .raddr(bit_idx[LK +: AW]),
    .rdata(exp_q));

  // sequencer FSM with registered outputs; write strobe/address trail the
  // RAM read address by one cycle so they line up with the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op          <= OP_SQR;
      bit_idx     <= '0;
      ld_addr     <= '0;
      wcnt        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mm_wr_ena   <= 1'b0;
      mm_wr_addr  <= '0;
      mm_wr_m1    <= '0;
      mm_task_req <= 1'b0;
    end else begin
      done       <= 1'b0;
      mm_wr_ena  <= (state == ST_LOAD);
      mm_wr_addr <= ld_addr;
      if (abort) begin
        state       <= ST_IDLE;
        op          <= OP_SQR;
        busy        <= 1'b0;
        mm_task_req <= 1'b0;
        mm_wr_ena   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              busy     <= 1'b1;
              err      <= 1'b0;
              mm_wr_m1 <= cfg_m1;
              op       <= OP_SQR;
              ld_addr  <= '0;
              wcnt     <= '0;
              if (eb == '0) begin
                state <= ST_DONE;
              end else begin
                bit_idx <= BW'(eb - 1'b1);
                state   <= ST_LOAD;
              end
            end
          end
          ST_LOAD: begin
            ld_addr <= ld_addr + 1'b1;
            if (ld_addr == LAST_A) begin
              wcnt  <= '0;
              state <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (mm_res_val && (wcnt <= N_WORDS)) wcnt <= wcnt + 1'b1;
            if (mm_task_end) begin
              mm_task_req <= 1'b0;
              state       <= ST_NEXT;
            end else begin
              mm_task_req <= 1'b1;
            end
          end
          ST_NEXT: begin
            if (wcnt != N_WORDS) err <= 1'b1;
            ld_addr <= '0;
            if ((op == OP_SQR) && exp_bit) begin
              op    <= OP_MUL;
              state <= ST_LOAD;
            end else if (bit_idx == '0) begin
              state <= ST_DONE;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              op      <= OP_SQR;
              state   <= ST_LOAD;
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mm_iddmm_modexp_seq.sv
// Bench for mm_iddmm_modexp_seq with K=16, N=2 and a behavioural
// bit-serial Montgomery core model; results are checked against plain
// modular arithmetic.
module tb_mm_iddmm_modexp_seq;
  import mm_iddmm_pkg::*;

  localparam int unsigned K  = 16;
  localparam int unsigned N  = 2;
  localparam int unsigned KN = K*N;
  localparam int unsigned EW = $clog2(KN+1);
  localparam int unsigned AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_wr_ena;
  logic [1:0]    cfg_wr_sel;
  logic [AW-1:0] cfg_wr_addr;
  logic [K-1:0]  cfg_wr_data;
  logic [K-1:0]  cfg_m1;
  logic [EW-1:0] exp_bits;
  logic          start, abort;
  logic          busy, done, err;
  logic [AW-1:0] rd_addr;
  logic [K-1:0]  rd_data;
  logic          mm_wr_ena;
  logic [AW-1:0] mm_wr_addr;
  logic [K-1:0]  mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1;
  logic          mm_task_req, mm_task_end, mm_res_val;
  logic [K-1:0]  mm_res;

  always #5 clk = ~clk;

  mm_iddmm_modexp_seq #(.K(K), .N(N), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_ena(cfg_wr_ena), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_m1(cfg_m1), .exp_bits(exp_bits),
    .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .mm_wr_ena(mm_wr_ena), .mm_wr_addr(mm_wr_addr), .mm_wr_x(mm_wr_x),
    .mm_wr_y(mm_wr_y), .mm_wr_m(mm_wr_m), .mm_wr_m1(mm_wr_m1),
    .mm_task_req(mm_task_req), .mm_task_end(mm_task_end),
    .mm_res_val(mm_res_val), .mm_res(mm_res));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic longint unsigned mulmod(input longint unsigned a, b, m);
    return (a * b) % m;
  endfunction

  // acc0 and base are Montgomery-form values; result is Montgomery form of
  // a^(2^L) * b^(e mod 2^L) where a, b are their plain-domain values
  function automatic logic [31:0] ref_result(input logic [31:0] m, base, acc0, e, input int L);
    longint unsigned mm, inv2, rinv, rmod, a, b, p;
    int lc;
    mm   = 64'(m);
    inv2 = (mm + 1) / 2;
    rinv = 1;
    for (int i = 0; i < int'(KN); i++) rinv = mulmod(rinv, inv2, mm);
    rmod = (64'd1 << KN) % mm;
    a  = mulmod(64'(acc0), rinv, mm);
    b  = mulmod(64'(base), rinv, mm);
    lc = (L > int'(KN)) ? int'(KN) : L;
    for (int i = 0; i < lc; i++) a = mulmod(a, a, mm);
    p = 1;
    for (int i = lc - 1; i >= 0; i--) begin
      p = mulmod(p, p, mm);
      if (e[i]) p = mulmod(p, b, mm);
    end
    return 32'(mulmod(mulmod(a, p, mm), rmod, mm));
  endfunction

  function automatic int ref_tasks(input logic [31:0] e, input int L);
    int lc, n;
    lc = (L > int'(KN)) ? int'(KN) : L;
    n  = lc;
    for (int i = 0; i < lc; i++) n += int'(e[i]);
    return n;
  endfunction

  function automatic logic [K-1:0] neg_minv(input logic [31:0] m);
    logic [K-1:0] inv, ml;
    ml  = m[K-1:0];
    inv = ml;
    for (int i = 0; i < 5; i++) inv = inv * (K'(2) - ml * inv);
    return -inv;
  endfunction

  // ---------------- core model ----------------
  logic [K-1:0] cx [N];
  logic [K-1:0] cy [N];
  logic [K-1:0] cm [N];
  int task_cnt = 0;
  bit short_mode = 1'b0;

  always @(negedge clk) begin
    if (rst_n && mm_wr_ena) begin
      cx[mm_wr_addr] <= mm_wr_x;
      cy[mm_wr_addr] <= mm_wr_y;
      cm[mm_wr_addr] <= mm_wr_m;
    end
  end

  function automatic logic [KN-1:0] mont(input logic [KN-1:0] x, y, m);
    logic [2*KN+1:0] t;
    t = x * y;
    for (int i = 0; i < int'(KN); i++) begin
      if (t[0]) t = t + m;
      t = t >> 1;
    end
    if (t >= m) t = t - m;
    return t[KN-1:0];
  endfunction

  initial begin : core_model
    logic [KN-1:0] xv, yv, mv, r;
    int cnt, dly, nw;
    bit active, ended;
    mm_res_val = 1'b0; mm_task_end = 1'b0; mm_res = '0;
    active = 1'b0; ended = 1'b0; cnt = 0; dly = 0; nw = 0; r = '0;
    forever begin
      @(posedge clk); #1;
      mm_res_val = 1'b0; mm_task_end = 1'b0;
      if (!active) begin
        if (mm_task_req) begin
          for (int i = 0; i < int'(N); i++) begin
            xv[i*K +: K] = cx[i]; yv[i*K +: K] = cy[i]; mv[i*K +: K] = cm[i];
          end
          r = mont(xv, yv, mv);
          active = 1'b1; ended = 1'b0; cnt = 0; dly = 2;
          nw = short_mode ? int'(N) - 1 : int'(N);
          task_cnt++;
        end
      end else if (!mm_task_req) begin
        active = 1'b0;
      end else if (dly > 0) begin
        dly--;
      end else if (cnt < nw) begin
        mm_res_val = 1'b1; mm_res = r[cnt*K +: K]; cnt++;
      end else if (!ended) begin
        mm_task_end = 1'b1; ended = 1'b1;
      end
    end
  end

  // ---------------- host tasks (all called at #1 after a posedge) ----------------
  typedef struct {
    logic [31:0] m, base, acc0, e;
    int          L;
    logic [31:0] exp_acc;
    int          exp_tasks;
  } vec_t;

  vec_t vecs[$];

  task automatic cfg_write(input logic [1:0] sel, input int a, input logic [K-1:0] d);
    cfg_wr_ena = 1'b1; cfg_wr_sel = sel; cfg_wr_addr = AW'(a); cfg_wr_data = d;
    @(posedge clk); #1;
    cfg_wr_ena = 1'b0;
  endtask

  task automatic write32(input logic [1:0] sel, input logic [31:0] v);
    for (int i = 0; i < int'(N); i++) cfg_write(sel, i, v[i*K +: K]);
  endtask

  task automatic load_vec(input vec_t v);
    write32(SEL_MOD, v.m);
    write32(SEL_BASE, v.base);
    write32(SEL_ACC, v.acc0);
    write32(SEL_EXP, v.e);
  endtask

  task automatic start_op(input int L, input logic [K-1:0] m1);
    exp_bits = EW'(L); cfg_m1 = m1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit got);
    cyc = 1; got = 1'b0;
    while (cyc < 5000 && !got) begin
      if (done) got = 1'b1;
      else begin @(posedge clk); #1; cyc++; end
    end
  endtask

  task automatic read_acc(output logic [31:0] v);
    for (int i = 0; i < int'(N); i++) begin
      rd_addr = AW'(i);
      @(posedge clk); #1;
      v[i*K +: K] = rd_data;
    end
  endtask

  function automatic vec_t mkvec(input logic [31:0] m, base, acc0, e, input int L,
                                 input logic [31:0] ea, input int et);
    vec_t v;
    v.m = m; v.base = base; v.acc0 = acc0; v.e = e; v.L = L; v.exp_acc = ea; v.exp_tasks = et;
    return v;
  endfunction

  localparam logic [31:0] M0 = 32'hFFFF_FFFB;

  initial begin
    vec_t v;
    logic [31:0] acc, rr;
    int cyc, n, dcnt;
    bit got;

    rst_n = 1'b0; cfg_wr_ena = 1'b0; cfg_wr_sel = '0; cfg_wr_addr = '0; cfg_wr_data = '0;
    cfg_m1 = '0; exp_bits = '0; start = 1'b0; abort = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_err", 64'(err), 0);
    check("rst_req", 64'(mm_task_req), 0);
    check("rst_wr", {mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_m1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table: constant expectations, clamp case, then randomized vectors
    vecs.push_back(mkvec(M0, 32'd10, 32'd5, 32'd5, 0, 32'd5,   0));
    vecs.push_back(mkvec(M0, 32'd10, 32'd5, 32'd5, 3, 32'hA0,  5));
    vecs.push_back(mkvec(M0, 32'd10, 32'd5, 32'd1, 1, 32'd10,  2));
    vecs.push_back(mkvec(M0, 32'd10, 32'd5, 32'd6, 3, 32'd320, 5));
    vecs.push_back(mkvec(M0, 32'd10, 32'd5, 32'hFFFF_FFFF, 40,
                         ref_result(M0, 32'd10, 32'd5, 32'hFFFF_FFFF, 40), 64));
    for (int i = 0; i < 8; i++) begin
      rr = $urandom(); v.m = rr | 32'h8000_0001;
      rr = $urandom(); v.base = rr % v.m;
      rr = $urandom(); v.acc0 = rr % v.m;
      v.e = $urandom();
      v.L = $urandom_range(0, 34);
      v.exp_acc = ref_result(v.m, v.base, v.acc0, v.e, v.L);
      v.exp_tasks = ref_tasks(v.e, v.L);
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      v = vecs[i];
      load_vec(v);
      task_cnt = 0;
      start_op(v.L, neg_minv(v.m));
      check($sformatf("v%0d_m1", i), 64'(mm_wr_m1), 64'(neg_minv(v.m)));
      check($sformatf("v%0d_busy", i), 64'(busy), 1);
      wait_done(cyc, got);
      check($sformatf("v%0d_done", i), 64'(got), 1);
      if (v.L == 0) check($sformatf("v%0d_latency", i), 64'(cyc), 2);
      check($sformatf("v%0d_busy_end", i), 64'(busy), 0);
      check($sformatf("v%0d_err", i), 64'(err), 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 64'(done), 0);
      check($sformatf("v%0d_tasks", i), 64'(task_cnt), 64'(v.exp_tasks));
      read_acc(acc);
      check($sformatf("v%0d_acc", i), 64'(acc), 64'(v.exp_acc));
    end

    // start and cfg writes while busy are ignored
    v = vecs[1];
    load_vec(v);
    task_cnt = 0;
    start_op(3, neg_minv(M0));
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; exp_bits = EW'(7);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_write(SEL_ACC, 0, 16'h1234);
    cfg_write(SEL_BASE, 0, 16'h0007);
    cfg_write(SEL_EXP, 0, 16'hFFFF);
    wait_done(cyc, got);
    check("busy_wr_done", 64'(got), 1);
    check("busy_wr_tasks", 64'(task_cnt), 5);
    read_acc(acc);
    check("busy_wr_acc", 64'(acc), 32'hA0);

    // abort during the second task
    load_vec(v);
    task_cnt = 0;
    start_op(3, neg_minv(M0));
    n = 0;
    while (task_cnt < 2 && n < 200) begin @(posedge clk); #1; n++; end
    check("abort_reach_task2", 64'(task_cnt), 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 0);
    check("abort_req", 64'(mm_task_req), 0);
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 64'(dcnt), 0);
    write32(SEL_ACC, 32'd5);
    task_cnt = 0;
    start_op(3, neg_minv(M0));
    wait_done(cyc, got);
    check("restart_done", 64'(got), 1);
    check("restart_tasks", 64'(task_cnt), 5);
    read_acc(acc);
    check("restart_acc", 64'(acc), 32'hA0);

    // short result stream sets err; next start clears it
    short_mode = 1'b1;
    load_vec(v);
    start_op(3, neg_minv(M0));
    wait_done(cyc, got);
    check("short_done", 64'(got), 1);
    check("short_err", 64'(err), 1);
    short_mode = 1'b0;
    load_vec(v);
    start_op(3, neg_minv(M0));
    check("err_cleared", 64'(err), 0);

    // reset in the middle of LOAD
    n = 0;
    while (!mm_wr_ena && n < 100) begin @(posedge clk); #1; n++; end
    check("load_seen", 64'(mm_wr_ena), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 0);
    check("midrst_req", 64'(mm_task_req), 0);
    check("midrst_wr", {mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m1}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_vec(v);
    task_cnt = 0;
    start_op(3, neg_minv(M0));
    wait_done(cyc, got);
    check("post_rst_done", 64'(got), 1);
    check("post_rst_tasks", 64'(task_cnt), 5);
    read_acc(acc);
    check("post_rst_acc", 64'(acc), 32'hA0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
